// File: rtl/seq_detector_param_if.sv
// Stream/status bundle for seq_detector_param.
// Optional care_mask signal is present only when SEQ_DET_MASK_EN is defined.
interface seq_detector_param_if #(
  parameter int unsigned LEN   = 4,
  parameter int unsigned CNT_W = 8
);
  localparam int unsigned FILL_W = $clog2(LEN + 1);

  logic              sync_clear;
  logic              in_valid;
  logic              din;
  logic              overlap_en;
`ifdef SEQ_DET_MASK_EN
  logic [LEN-1:0]    care_mask;
`endif
  logic              match;
  logic              match_q;
  logic [CNT_W-1:0]  match_count;
  logic [FILL_W-1:0] fill;

`ifdef SEQ_DET_MASK_EN
  // Upstream serialiser side
  modport master (
    output sync_clear, in_valid, din, overlap_en, care_mask,
    input  match, match_q, match_count, fill
  );
  // Detector side
  modport slave (
    input  sync_clear, in_valid, din, overlap_en, care_mask,
    output match, match_q, match_count, fill
  );
`else
  // Upstream serialiser side
  modport master (
    output sync_clear, in_valid, din, overlap_en,
    input  match, match_q, match_count, fill
  );
  // Detector side
  modport slave (
    input  sync_clear, in_valid, din, overlap_en,
    output match, match_q, match_count, fill
  );
`endif
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with overlap control, Mealy match,
// registered match flag and saturating hit counter.
// Define SEQ_DET_MASK_EN to enable per-bit don't-care masking via care_mask.
// Detection phase is implicit in fill: EMPTY (0), FILLING (<LEN-1), ARMED (>=LEN-1).
module seq_detector_param #(
  parameter int unsigned    LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = LEN'(4'b1011),
  parameter int unsigned    CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 async_reset_n,
  seq_detector_param_if.slave  bus
);

  localparam int unsigned FILL_W = $clog2(LEN + 1);
  localparam int unsigned HIST_W = LEN - 1;

  // Only the newest LEN-1 bits can ever reach the comparator, so the oldest
  // history bit is not stored.
  logic [HIST_W-1:0] hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;
  logic              match_r_q, match_r_d;

  logic [LEN-1:0]    cand;
  logic              hit;
  logic              armed;
  logic              match_c;

  // Candidate word and comparator (Mealy path)
  always_comb begin
    cand = {hist_q, bus.din};
`ifdef SEQ_DET_MASK_EN
    hit  = ((cand ^ PATTERN) & bus.care_mask) == '0;
`else
    hit  = (cand == PATTERN);
`endif
    armed   = (fill_q >= FILL_W'(LEN - 1));
    match_c = bus.in_valid & ~bus.sync_clear & armed & hit;
  end

  // Next-state: clear > match > shift > hold
  always_comb begin
    hist_d    = hist_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;
    match_r_d = match_c;
    if (bus.sync_clear) begin
      hist_d    = '0;
      fill_d    = '0;
      cnt_d     = '0;
      match_r_d = 1'b0;
    end else if (match_c) begin
      if (~&cnt_q) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (bus.overlap_en) begin
        hist_d = cand[HIST_W-1:0];
        fill_d = FILL_W'(LEN);
      end else begin
        hist_d = '0;
        fill_d = '0;
      end
    end else if (bus.in_valid) begin
      hist_d = cand[HIST_W-1:0];
      if (fill_q != FILL_W'(LEN)) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      hist_q    <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
      match_r_q <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
      match_r_q <= match_r_d;
    end
  end

  assign bus.match       = match_c;
  assign bus.match_q     = match_r_q;
  assign bus.match_count = cnt_q;
  assign bus.fill        = fill_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param (LEN=4, PATTERN=1011, CNT_W=2).
// Mask checks run only when SEQ_DET_MASK_EN is defined.
module tb_seq_detector_param;

  logic clk;
  logic async_reset_n;

  seq_detector_param_if #(.LEN(4), .CNT_W(2)) bus ();

  seq_detector_param #(.LEN(4), .PATTERN(4'b1011), .CNT_W(2)) dut (
    .clk           (clk),
    .async_reset_n (async_reset_n),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int id;
    int m;
    int cnt;
    int fill;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue the hand-computed response
  task automatic step(input logic v, input logic d, input logic ov, input logic clr,
                      input int em, input int ec, input int ef);
    exp_t e;
    @(negedge clk);
    bus.in_valid   = v;
    bus.din        = d;
    bus.overlap_en = ov;
    bus.sync_clear = clr;
    step_id++;
    e.id   = step_id;
    e.m    = em;
    e.cnt  = ec;
    e.fill = ef;
    sb_q.push_back(e);
  endtask

  // Monitor: Mealy match before the edge, registered state after it
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check($sformatf("match@%0d", e.id), int'(bus.match), e.m);
        @(posedge clk);
        #1;
        check($sformatf("match_q@%0d", e.id), int'(bus.match_q), e.m);
        check($sformatf("count@%0d", e.id), int'(bus.match_count), e.cnt);
        check($sformatf("fill@%0d", e.id), int'(bus.fill), e.fill);
      end
    end
  end

  int sat_bits[16] = '{1,0,1,1, 0,1,1, 0,1,1, 0,1,1, 0,1,1};
  int sat_m[16]    = '{0,0,0,1, 0,0,1, 0,0,1, 0,0,1, 0,0,1};
  int sat_cnt[16]  = '{0,0,0,1, 1,1,2, 2,2,3, 3,3,3, 3,3,3};
  int sat_fill[16] = '{1,2,3,4, 4,4,4, 4,4,4, 4,4,4, 4,4,4};

  initial begin
    async_reset_n  = 1'b0;
    bus.in_valid   = 1'b0;
    bus.din        = 1'b0;
    bus.overlap_en = 1'b1;
    bus.sync_clear = 1'b0;
`ifdef SEQ_DET_MASK_EN
    bus.care_mask  = 4'b1111;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_fill", int'(bus.fill), 0);
    check("rst_count", int'(bus.match_count), 0);
    check("rst_match_q", int'(bus.match_q), 0);
    check("rst_match", int'(bus.match), 0);
    @(negedge clk);
    async_reset_n = 1'b1;

    // Overlapping: 1011011 -> matches on bits 4 and 7
    step(1,1,1,0, 0,0,1); step(1,0,1,0, 0,0,2); step(1,1,1,0, 0,0,3);
    step(1,1,1,0, 1,1,4); step(1,0,1,0, 0,1,4); step(1,1,1,0, 0,1,4);
    step(1,1,1,0, 1,2,4);
    step(0,0,1,1, 0,0,0);

    // Non-overlapping: same stream -> single match, fill 3 at the end
    step(1,1,0,0, 0,0,1); step(1,0,0,0, 0,0,2); step(1,1,0,0, 0,0,3);
    step(1,1,0,0, 1,1,0); step(1,0,0,0, 0,1,1); step(1,1,0,0, 0,1,2);
    step(1,1,0,0, 0,1,3);
    step(0,0,1,1, 0,0,0);

    // Valid gaps do not shift history, even when din would complete a match
    step(1,1,1,0, 0,0,1); step(1,0,1,0, 0,0,2);
    step(0,1,1,0, 0,0,2); step(0,1,1,0, 0,0,2); step(0,1,1,0, 0,0,2);
    step(1,1,1,0, 0,0,3); step(0,1,1,0, 0,0,3);
    step(1,1,1,0, 1,1,4);
    step(0,0,1,1, 0,0,0);

    // Counter saturation at 3 with CNT_W=2
    for (int i = 0; i < 16; i++) begin
      step(1, 1'(sat_bits[i]), 1, 0, sat_m[i], sat_cnt[i], sat_fill[i]);
    end

    // Partial history 1,0,1 (no match), then async reset mid-cycle with a completing bit
    step(1,1,1,0, 0,3,4); step(1,0,1,0, 0,3,4); step(1,1,1,0, 0,3,4);
    @(posedge clk);
    #3;
    bus.in_valid  = 1'b1;
    bus.din       = 1'b1;
    async_reset_n = 1'b0;
    #1;
    check("arst_match", int'(bus.match), 0);
    check("arst_fill", int'(bus.fill), 0);
    check("arst_count", int'(bus.match_count), 0);
    check("arst_match_q", int'(bus.match_q), 0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    async_reset_n = 1'b1;
    step(1,1,1,0, 0,0,1);

    // Build to a match, then sync_clear overrides a completing bit
    step(1,0,1,0, 0,0,2); step(1,1,1,0, 0,0,3); step(1,1,1,0, 1,1,4);
    step(1,0,1,0, 0,1,4); step(1,1,1,0, 0,1,4);
    step(1,1,1,1, 0,0,0);
    step(1,1,1,0, 0,0,1); step(1,0,1,0, 0,0,2); step(1,1,1,0, 0,0,3);
    step(1,1,1,0, 1,1,4);

`ifdef SEQ_DET_MASK_EN
    step(0,0,1,1, 0,0,0);
    @(negedge clk);
    bus.care_mask = 4'b1001;
    step(1,1,1,0, 0,0,1); step(1,1,1,0, 0,0,2); step(1,0,1,0, 0,0,3);
    step(1,1,1,0, 1,1,4);
    step(1,0,1,0, 0,1,4); step(1,0,1,0, 0,1,4); step(1,0,1,0, 0,1,4);
    step(1,1,1,0, 0,1,4);
    @(negedge clk);
    bus.care_mask = 4'b0000;
    step(1,0,1,0, 1,2,4);
    @(negedge clk);
    bus.care_mask = 4'b1111;
`endif

    @(negedge clk);
    bus.in_valid   = 1'b0;
    bus.sync_clear = 1'b0;
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) begin
      @(negedge clk);
    end
    check("scoreboard_drained", sb_q.size(), 0);
    @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial pattern detector; successor to the fixed 2-bit-state A/B detector FSM.
- Detects a compile-time LEN-bit PATTERN on a qualified serial input.
- Supports runtime overlapping or non-overlapping detection.
- Provides a Mealy match pulse, a registered match flag and a saturating hit counter.
- Sits between an input synchroniser/serialiser and the lab's display/count logic.

Parameters:
- LEN, 4, pattern length in bits; legal range 2..32.
- PATTERN, 4'b1011, LEN-bit target; MSB is the first bit received.
- CNT_W, 8, width of match_count.

Ports:
- clk  input  1  rising-edge clock.
- async_reset_n  input  1  asynchronous active-low reset.
- sync_clear  input  1  synchronous clear of history, fill and counter.
- in_valid  input  1  din qualifier; din is consumed only when in_valid=1.
- din  input  1  serial data bit.
- overlap_en  input  1  1 = overlapping detection; 0 = restart after each match.
- match  output  1  Mealy, combinational; high in the cycle the completing bit is presented.
- match_q  output  1  match registered; high for one cycle after each match.
- match_count  output  CNT_W  number of matches, saturating.
- fill  output  $clog2(LEN+1)  valid history bits held, 0..LEN.

Behaviour:
- Reset: async_reset_n=0 immediately clears hist (LEN bits), fill, match_q and match_count to 0.
  - match is 0 while reset is asserted.
  - Reset mid-stream discards all partial history.
- State:
  - hist[LEN-1:0] holds the most recent accepted bits; hist[0] is the newest.
  - fill counts accepted bits since the last restart, saturating at LEN.
- Candidate: cand = {hist[LEN-2:0], din}.
- match = in_valid & ~sync_clear & (fill >= LEN-1) & (cand == PATTERN). Zero latency.
- On a clock edge with in_valid=1 and match=0: hist <= cand; fill <= min(fill+1, LEN).
- On a clock edge with match=1:
  - overlap_en=1: hist <= cand; fill <= LEN. The tail of the match may start the next match.
  - overlap_en=0: hist <= 0; fill <= 0. The next match needs LEN fresh bits.
  - match_count increments by 1 unless it is all ones; it then holds (saturation, no wrap).
- in_valid=0: hist, fill and match_count hold; match=0. Gaps do not shift history.
- match_q <= match every cycle.
- sync_clear=1 at a clock edge:
  - hist, fill, match_count and match_q go to 0.
  - It overrides a simultaneous valid bit; that bit is dropped and match is forced 0 that cycle.
- Priority: async_reset_n > sync_clear > match update > shift update > hold.
- overlap_en is sampled only in the match cycle and may change at any time.
- Implementation: plain registers plus comparator.
  - The FSM is implicit in fill: states EMPTY (fill=0), FILLING (0<fill<LEN-1) and ARMED (fill>=LEN-1).
  - Transitions are as above.

Optional Feature:
- Macro: SEQ_DET_MASK_EN.
- Defined:
  - Adds input port care_mask [LEN-1:0].
  - Comparison becomes ((cand ^ PATTERN) & care_mask) == 0; mask bits at 0 are don't-care.
  - care_mask=0 with fill >= LEN-1 matches on every valid bit.
  - care_mask is sampled combinationally.
- Undefined: port absent; exact compare against PATTERN.

Test Plan:
- Overlap: LEN=4, PATTERN=1011, overlap_en=1, valid stream 1,0,1,1,0,1,1 -> match on bits 4 and 7; match_q one cycle later each time; match_count=2.
- Non-overlap: same stream, overlap_en=0 -> match only on bit 4; fill=3 after bit 7; match_count=1.
- Valid gaps: bits 1,0 then in_valid=0 for 3 cycles, then 1,1 -> no shifts during gaps; match on the 4th valid bit; fill held at 2 during gaps.
- Saturation: CNT_W=2, overlap_en=1, stream 1011011011011011 -> 5 matches; match_count stays 3 from the 3rd match onward; match still pulses each time.
- Reset/clear:
  - Feed 1,0,1, pulse async_reset_n low mid-cycle, then feed 1 -> outputs 0 immediately, no match, fill=1.
  - Separately, assert sync_clear with the completing bit 1 of 1011 -> match=0; match_count=0 and fill=0 next cycle.
- Mask (SEQ_DET_MASK_EN): care_mask=4'b1001, stream 1,1,0,1 -> match on bit 4; stream 0,0,0,1 -> no match.
